// File: rtl/bsg_cache_to_axi_rx_id_routed.sv
// Multi-cache AXI4 read engine: cache tag issued as ARID, R beats routed per beat by RID, serialized into cache words.
// Latency: AR is combinational from v_i; R handshake to dma_data_v_o is 1 cycle; one word per cycle per held beat.
// Backpressure: per-cache AR credits gate arvalid; a stalled cache holds the beat register and deasserts rready for all.
module bsg_cache_to_axi_rx_id_routed #(
    parameter int num_cache_p           = 4,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int max_outstanding_p     = 2,
    parameter int axi_id_width_p        = 4,
    parameter int axi_addr_width_p      = 32,
    parameter int axi_data_width_p      = 64,
    parameter int axi_burst_len_p       = 4,
    parameter int lg_num_cache_lp       = (num_cache_p > 1) ? $clog2(num_cache_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic                                  v_i,
    output logic                                  yumi_o,
    input  logic [lg_num_cache_lp-1:0]            tag_i,
    input  logic [axi_addr_width_p-1:0]           axi_addr_i,

    output logic [num_cache_p*data_width_p-1:0]   dma_data_o,
    output logic [num_cache_p-1:0]                dma_data_v_o,
    input  logic [num_cache_p-1:0]                dma_data_ready_i,

    output logic [axi_id_width_p-1:0]             axi_arid_o,
    output logic [axi_addr_width_p-1:0]           axi_araddr_o,
    output logic [7:0]                            axi_arlen_o,
    output logic [2:0]                            axi_arsize_o,
    output logic [1:0]                            axi_arburst_o,
    output logic [3:0]                            axi_arcache_o,
    output logic [2:0]                            axi_arprot_o,
    output logic                                  axi_arlock_o,
    output logic                                  axi_arvalid_o,
    input  logic                                  axi_arready_i,

    input  logic [axi_id_width_p-1:0]             axi_rid_i,
    input  logic [axi_data_width_p-1:0]           axi_rdata_i,
    input  logic [1:0]                            axi_rresp_i,
    input  logic                                  axi_rlast_i,
    input  logic                                  axi_rvalid_i,
    output logic                                  axi_rready_o,

    output logic [num_cache_p-1:0]                err_o,
    output logic                                  bad_id_o
);

    localparam int ratio_lp     = axi_data_width_p / data_width_p;
    localparam int lg_ratio_lp  = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int lg_block_lp  = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam int cnt_w_lp     = $clog2(max_outstanding_p + 1);
    localparam int ratio_m1_int_lp = ratio_lp - 1;
    localparam int block_m1_int_lp = block_size_in_words_p - 1;
    localparam int arlen_int_lp    = axi_burst_len_p - 1;
    localparam int arsize_int_lp   = $clog2(axi_data_width_p / 8);

    localparam logic [lg_ratio_lp-1:0]    ratio_m1_lp = ratio_m1_int_lp[lg_ratio_lp-1:0];
    localparam logic [lg_block_lp-1:0]    block_m1_lp = block_m1_int_lp[lg_block_lp-1:0];
    localparam logic [cnt_w_lp-1:0]       max_cnt_lp  = max_outstanding_p[cnt_w_lp-1:0];
    localparam logic [axi_id_width_p:0]   num_id_lp   = num_cache_p[axi_id_width_p:0];

    // per-cache state
    logic [cnt_w_lp-1:0]    out_cnt [num_cache_p];
    logic [lg_block_lp-1:0] wcnt    [num_cache_p];

    // held beat
    logic                          held;
    logic [axi_id_width_p-1:0]     h_rid;
    logic [axi_data_width_p-1:0]   h_data;
    logic [1:0]                    h_resp;
    logic                          h_last;
    logic [lg_ratio_lp-1:0]        widx;

    logic [lg_num_cache_lp-1:0]    rid_idx;
    logic                          h_bad;
    logic                          good;
    logic                          word_yumi;
    logic                          beat_last_word;
    logic                          block_done;
    logic                          beat_done;
    logic                          r_hs;
    logic [data_width_p-1:0]       word;

    // AR channel: credit-gated request, fixed burst shape
    always_comb begin
        axi_arvalid_o = v_i & (out_cnt[tag_i] < max_cnt_lp);
        yumi_o        = axi_arvalid_o & axi_arready_i;
        axi_arid_o    = '0;
        axi_arid_o[lg_num_cache_lp-1:0] = tag_i;
        axi_araddr_o  = axi_addr_i;
        axi_arlen_o   = arlen_int_lp[7:0];
        axi_arsize_o  = arsize_int_lp[2:0];
        axi_arburst_o = 2'b01;
        axi_arcache_o = 4'b0000;
        axi_arprot_o  = 3'b000;
        axi_arlock_o  = 1'b0;
    end

    // serializer view of the held beat; bad-ID beats drain immediately without delivery
    always_comb begin
        rid_idx        = h_rid[lg_num_cache_lp-1:0];
        h_bad          = ({1'b0, h_rid} >= num_id_lp);
        good           = held & ~h_bad;
        word           = h_data[widx*data_width_p +: data_width_p];
        word_yumi      = good & dma_data_ready_i[rid_idx];
        beat_last_word = (widx == ratio_m1_lp);
        block_done     = word_yumi & (wcnt[rid_idx] == block_m1_lp);
        beat_done      = (held & h_bad) | (word_yumi & beat_last_word);
        axi_rready_o   = ~held | beat_done;
        r_hs           = axi_rvalid_i & axi_rready_o;
        dma_data_o     = {num_cache_p{word}};
        dma_data_v_o   = '0;
        if (good) dma_data_v_o[rid_idx] = 1'b1;
    end

    // beat register and word index; a new beat may load in the cycle the old one finishes
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held     <= 1'b0;
            h_rid    <= '0;
            h_data   <= '0;
            h_resp   <= '0;
            h_last   <= 1'b0;
            widx     <= '0;
            bad_id_o <= 1'b0;
        end else begin
            if (beat_done) held <= 1'b0;
            if (word_yumi) widx <= beat_last_word ? '0 : widx + 1'b1;
            if (r_hs) begin
                held   <= 1'b1;
                h_rid  <= axi_rid_i;
                h_data <= axi_rdata_i;
                h_resp <= axi_rresp_i;
                h_last <= axi_rlast_i;
                widx   <= '0;
                if ({1'b0, axi_rid_i} >= num_id_lp) bad_id_o <= 1'b1;
            end
        end
    end

    // per-cache credits, block word counts and sticky error flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_cache_p; c++) begin
                out_cnt[c] <= '0;
                wcnt[c]    <= '0;
            end
            err_o <= '0;
        end else begin
            for (int c = 0; c < num_cache_p; c++) begin
                logic inc, dec;
                inc = yumi_o & (tag_i == c[lg_num_cache_lp-1:0]);
                dec = block_done & (rid_idx == c[lg_num_cache_lp-1:0]);
                if (inc & ~dec) out_cnt[c] <= out_cnt[c] + 1'b1;
                else if (dec & ~inc) out_cnt[c] <= out_cnt[c] - 1'b1;
                if (word_yumi && (rid_idx == c[lg_num_cache_lp-1:0])) begin
                    wcnt[c] <= (wcnt[c] == block_m1_lp) ? '0 : wcnt[c] + 1'b1;
                    if (beat_last_word &&
                        ((h_resp != 2'b00) || (h_last != (wcnt[c] == block_m1_lp))))
                        err_o[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_cache_to_axi_rx_id_routed.sv
module tb_bsg_cache_to_axi_rx_id_routed;
    localparam int NC = 4, DW = 32, AXW = 64, BLK = 8, BL = 4, IDW = 4, AW = 32, RATIO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i;
    logic              v_i, yumi_o;
    logic [1:0]        tag_i;
    logic [AW-1:0]     axi_addr_i;
    logic [NC*DW-1:0]  dma_data_o;
    logic [NC-1:0]     dma_data_v_o, dma_data_ready_i;
    logic [IDW-1:0]    axi_arid_o;
    logic [AW-1:0]     axi_araddr_o;
    logic [7:0]        axi_arlen_o;
    logic [2:0]        axi_arsize_o, axi_arprot_o;
    logic [1:0]        axi_arburst_o;
    logic [3:0]        axi_arcache_o;
    logic              axi_arlock_o, axi_arvalid_o, axi_arready_i;
    logic [IDW-1:0]    axi_rid_i;
    logic [AXW-1:0]    axi_rdata_i;
    logic [1:0]        axi_rresp_i;
    logic              axi_rlast_i, axi_rvalid_i, axi_rready_o;
    logic [NC-1:0]     err_o;
    logic              bad_id_o;

    bsg_cache_to_axi_rx_id_routed #(
        .num_cache_p(NC), .data_width_p(DW), .block_size_in_words_p(BLK),
        .max_outstanding_p(2), .axi_id_width_p(IDW), .axi_addr_width_p(AW),
        .axi_data_width_p(AXW), .axi_burst_len_p(BL)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .v_i(v_i), .yumi_o(yumi_o), .tag_i(tag_i), .axi_addr_i(axi_addr_i),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arcache_o(axi_arcache_o),
        .axi_arprot_o(axi_arprot_o), .axi_arlock_o(axi_arlock_o), .axi_arvalid_o(axi_arvalid_o),
        .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
        .err_o(err_o), .bad_id_o(bad_id_o)
    );

    int n_cmp = 0, n_fail = 0;

    // reference model: per-cache expected word streams, beat position within burst, sticky flags
    logic [DW-1:0] got   [NC][$];
    logic [DW-1:0] exp_q [NC][$];
    int            bi [NC];
    logic [NC-1:0] exp_err;
    logic          exp_bad;
    logic [NC-1:0] seen;

    // record every word a cache accepts and every lane that ever showed valid
    always @(negedge clk) begin
        if (!reset_i) begin
            for (int c = 0; c < NC; c++)
                if (dma_data_v_o[c] && dma_data_ready_i[c]) got[c].push_back(dma_data_o[c*DW +: DW]);
            seen = seen | dma_data_v_o;
        end
    end

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            got[c].delete();
            exp_q[c].delete();
            bi[c] = 0;
        end
        exp_err = '0;
        exp_bad = 1'b0;
        seen    = '0;
    endtask

    task automatic model_beat(input int id, input logic [AXW-1:0] d, input logic [1:0] resp, input logic last);
        if (id >= NC) exp_bad = 1'b1;
        else begin
            for (int w = 0; w < RATIO; w++) exp_q[id].push_back(d[w*DW +: DW]);
            if (resp != 2'b00 || last != (bi[id] == BL-1)) exp_err[id] = 1'b1;
            bi[id] = (bi[id] + 1) % BL;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; v_i = 1'b0; tag_i = '0; axi_addr_i = '0;
        axi_rvalid_i = 1'b0; axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 1'b0;
        dma_data_ready_i = '1; axi_arready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset_i = 1'b0;
    endtask

    task automatic send_beat(input int id, input logic [AXW-1:0] d, input logic [1:0] resp, input logic last);
        logic hs;
        hs = 1'b0;
        axi_rid_i = id[IDW-1:0]; axi_rdata_i = d; axi_rresp_i = resp; axi_rlast_i = last; axi_rvalid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); hs = axi_rready_o;
            @(posedge clk); #1;
            if (hs) break;
        end
        axi_rvalid_i = 1'b0;
        if (hs) model_beat(id, d, resp, last);
        else begin
            n_cmp++; n_fail++;
            $display("FAIL r_handshake id=%0d rready never seen, required within 200 cycles", id);
        end
    endtask

    task automatic send_burst(input int id);
        for (int b = 0; b < BL; b++) send_beat(id, {$urandom, $urandom}, 2'b00, b == BL-1);
    endtask

    task automatic issue_req(input int tag);
        logic hs;
        hs = 1'b0;
        v_i = 1'b1; tag_i = tag[1:0]; axi_addr_i = $urandom;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); hs = yumi_o;
            @(posedge clk); #1;
            if (hs) break;
        end
        v_i = 1'b0;
        if (!hs) begin
            n_cmp++; n_fail++;
            $display("FAIL ar_handshake tag=%0d yumi never seen, required within 50 cycles", tag);
        end
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            ok = 1'b1;
            for (int c = 0; c < NC; c++) if (got[c].size() != exp_q[c].size()) ok = 1'b0;
            if (!ok) begin @(posedge clk); #1; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL drain words still outstanding after 400 cycles, required all delivered");
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (yumi_o !== 1'b0)       begin n_fail++; $display("FAIL rst_yumi got=%b exp=0", yumi_o); end
        n_cmp++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got=%b exp=0", axi_arvalid_o); end
        n_cmp++; if (dma_data_v_o !== '0)   begin n_fail++; $display("FAIL rst_dma_v got=%b exp=0", dma_data_v_o); end
        n_cmp++; if (axi_rready_o !== 1'b1) begin n_fail++; $display("FAIL rst_rready got=%b exp=1", axi_rready_o); end
        n_cmp++; if (err_o !== '0)          begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_o); end
        n_cmp++; if (bad_id_o !== 1'b0)     begin n_fail++; $display("FAIL rst_bad_id got=%b exp=0", bad_id_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_ar_fields();
        logic [AXW-1:0] d;
        do_reset();
        v_i = 1'b1; tag_i = 2'd2; axi_addr_i = 32'h1000;
        @(negedge clk);
        n_cmp++; if (axi_arvalid_o !== 1'b1 || yumi_o !== 1'b1)
            begin n_fail++; $display("FAIL ar_valid got=%b/%b exp=1/1", axi_arvalid_o, yumi_o); end
        n_cmp++; if (axi_arid_o !== 4'd2)        begin n_fail++; $display("FAIL ar_id got=%0d exp=2", axi_arid_o); end
        n_cmp++; if (axi_araddr_o !== 32'h1000)  begin n_fail++; $display("FAIL ar_addr got=%h exp=1000", axi_araddr_o); end
        n_cmp++; if (axi_arlen_o !== 8'd3)       begin n_fail++; $display("FAIL ar_len got=%0d exp=3", axi_arlen_o); end
        n_cmp++; if (axi_arsize_o !== 3'd3)      begin n_fail++; $display("FAIL ar_size got=%0d exp=3", axi_arsize_o); end
        n_cmp++; if ({axi_arburst_o, axi_arcache_o, axi_arprot_o, axi_arlock_o} !== {2'b01, 8'h00})
            begin n_fail++; $display("FAIL ar_fixed got=%b/%b/%b/%b exp=01/0/0/0", axi_arburst_o, axi_arcache_o, axi_arprot_o, axi_arlock_o); end
        @(posedge clk); #1;
        v_i = 1'b0;
        d = {32'hB000_0000, 32'hA000_0000};
        send_beat(2, d, 2'b00, 1'b0);
        @(negedge clk);
        n_cmp++; if (dma_data_v_o !== 4'b0100 || dma_data_o[2*DW +: DW] !== 32'hA000_0000)
            begin n_fail++; $display("FAIL r_latency got v=%b w=%h exp v=0100 w=a0000000", dma_data_v_o, dma_data_o[2*DW +: DW]); end
        @(posedge clk); #1;
        for (int b = 1; b < BL; b++) begin
            d = {32'hB000_0000 + b, 32'hA000_0000 + b};
            send_beat(2, d, 2'b00, b == BL-1);
        end
        wait_drain();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (got[c].size() !== exp_q[c].size()) begin n_fail++; $display("FAIL ar_count c=%0d got=%0d exp=%0d", c, got[c].size(), exp_q[c].size()); end
            else for (int i = 0; i < got[c].size(); i++) begin
                n_cmp++; if (got[c][i] !== exp_q[c][i]) begin n_fail++; $display("FAIL ar_word c=%0d i=%0d got=%h exp=%h", c, i, got[c][i], exp_q[c][i]); end
            end
        end
        n_cmp++; if (seen !== 4'b0100) begin n_fail++; $display("FAIL ar_lanes got=%b exp=0100", seen); end
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL ar_err got=%b exp=%b", err_o, exp_err); end
    endtask

    task automatic test_credit();
        int  ny;
        logic took7, early, done;
        do_reset();
        ny = 0;
        v_i = 1'b1; tag_i = 2'd1; axi_addr_i = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); if (yumi_o) ny++;
            @(posedge clk); #1;
        end
        n_cmp++; if (ny !== 2) begin n_fail++; $display("FAIL credit_yumis got=%0d exp=2", ny); end
        send_burst(1);
        took7 = 1'b0; early = 1'b0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); #1;
            if (took7) begin
                done = 1'b1;
                n_cmp++; if (axi_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL credit_return arvalid got=%b exp=1", axi_arvalid_o); end
            end else begin
                if (axi_arvalid_o) early = 1'b1;
                if (dma_data_v_o[1] && got[1].size() == BLK) took7 = 1'b1;
            end
            @(posedge clk); #1;
        end
        v_i = 1'b0;
        n_cmp++; if (early || !done) begin n_fail++; $display("FAIL credit_block early=%b returned=%b exp early=0 returned=1", early, done); end
        send_burst(1);
        send_burst(1);
        wait_drain();
        n_cmp++;
        if (got[1].size() !== exp_q[1].size()) begin n_fail++; $display("FAIL credit_count got=%0d exp=%0d", got[1].size(), exp_q[1].size()); end
        else for (int i = 0; i < got[1].size(); i++) begin
            n_cmp++; if (got[1][i] !== exp_q[1][i]) begin n_fail++; $display("FAIL credit_word i=%0d got=%h exp=%h", i, got[1][i], exp_q[1][i]); end
        end
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL credit_err got=%b exp=%b", err_o, exp_err); end
    endtask

    task automatic test_interleave();
        logic stop;
        int   ny;
        do_reset();
        issue_req(0);
        issue_req(3);
        stop = 1'b0;
        fork
            begin
                for (int b = 0; b < BL; b++) begin
                    send_beat(0, {$urandom, $urandom}, 2'b00, b == BL-1);
                    send_beat(3, {$urandom, $urandom}, 2'b00, b == BL-1);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    dma_data_ready_i = 4'($urandom);
                    @(posedge clk); #1;
                end
            end
        join
        dma_data_ready_i = '1;
        wait_drain();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (got[c].size() !== exp_q[c].size()) begin n_fail++; $display("FAIL il_count c=%0d got=%0d exp=%0d", c, got[c].size(), exp_q[c].size()); end
            else for (int i = 0; i < got[c].size(); i++) begin
                n_cmp++; if (got[c][i] !== exp_q[c][i]) begin n_fail++; $display("FAIL il_word c=%0d i=%0d got=%h exp=%h", c, i, got[c][i], exp_q[c][i]); end
            end
        end
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL il_err got=%b exp=%b", err_o, exp_err); end
        for (int t = 0; t < NC; t += 3) begin
            ny = 0;
            v_i = 1'b1; tag_i = t[1:0];
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); if (yumi_o) ny++;
                @(posedge clk); #1;
            end
            v_i = 1'b0;
            n_cmp++; if (ny !== 2) begin n_fail++; $display("FAIL il_credits tag=%0d got=%0d exp=2", t, ny); end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] hold;
        do_reset();
        issue_req(0);
        fork
            send_burst(0);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk); #1;
                    if (got[0].size() >= 1) break;
                end
                @(posedge clk); #1;
                dma_data_ready_i[0] = 1'b0;
                hold = exp_q[0][1];
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    n_cmp++;
                    if (dma_data_v_o[0] !== 1'b1 || dma_data_o[DW-1:0] !== hold || axi_rready_o !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold cyc=%0d got v=%b w=%h rready=%b exp v=1 w=%h rready=0",
                                 k, dma_data_v_o[0], dma_data_o[DW-1:0], axi_rready_o, hold);
                    end
                    @(posedge clk); #1;
                end
                dma_data_ready_i[0] = 1'b1;
            end
        join
        wait_drain();
        n_cmp++;
        if (got[0].size() !== BLK) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", got[0].size(), BLK); end
        else for (int i = 0; i < BLK; i++) begin
            n_cmp++; if (got[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL stall_word i=%0d got=%h exp=%h", i, got[0][i], exp_q[0][i]); end
        end
    endtask

    task automatic test_errors();
        int total;
        do_reset();
        issue_req(0);
        for (int b = 0; b < BL; b++) send_beat(0, {$urandom, $urandom}, (b == 1) ? 2'b10 : 2'b00, b == BL-1);
        wait_drain();
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL err_rresp got=%b exp=%b", err_o, exp_err); end
        n_cmp++; if (got[0].size() !== BLK || got[0][2] !== exp_q[0][2] || got[0][3] !== exp_q[0][3])
            begin n_fail++; $display("FAIL err_delivered got n=%0d exp n=%0d with beat 1 words intact", got[0].size(), BLK); end
        issue_req(1);
        for (int b = 0; b < BL; b++) send_beat(1, {$urandom, $urandom}, 2'b00, b == 1);
        wait_drain();
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL err_rlast got=%b exp=%b", err_o, exp_err); end
        issue_req(0);
        send_burst(0);
        wait_drain();
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL err_sticky got=%b exp=%b", err_o, exp_err); end
        seen = '0;
        total = got[0].size() + got[1].size() + got[2].size() + got[3].size();
        send_beat(5, {$urandom, $urandom}, 2'b00, 1'b1);
        @(negedge clk);
        n_cmp++; if (bad_id_o !== exp_bad || axi_rready_o !== 1'b1 || dma_data_v_o !== '0)
            begin n_fail++; $display("FAIL bad_id got bad=%b rready=%b v=%b exp bad=%b rready=1 v=0", bad_id_o, axi_rready_o, dma_data_v_o, exp_bad); end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (seen !== '0 || total !== got[0].size() + got[1].size() + got[2].size() + got[3].size())
            begin n_fail++; $display("FAIL bad_id_drop got lanes=%b words=%0d exp lanes=0 words=%0d", seen,
                     got[0].size() + got[1].size() + got[2].size() + got[3].size(), total); end
        n_cmp++; if (bad_id_o !== 1'b1) begin n_fail++; $display("FAIL bad_id_sticky got=%b exp=1", bad_id_o); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        issue_req(1);
        send_beat(1, {$urandom, $urandom}, 2'b00, 1'b0);
        send_beat(1, {$urandom, $urandom}, 2'b00, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (got[1].size() >= 3) break;
        end
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++; if ({yumi_o, axi_arvalid_o, dma_data_v_o, axi_rready_o, err_o, bad_id_o} !== {2'b00, 4'b0000, 1'b1, 4'b0000, 1'b0})
            begin n_fail++; $display("FAIL mid_reset got yumi=%b arv=%b v=%b rready=%b err=%b bad=%b exp 0 0 0000 1 0000 0",
                     yumi_o, axi_arvalid_o, dma_data_v_o, axi_rready_o, err_o, bad_id_o); end
        @(posedge clk); #1;
        issue_req(1);
        send_burst(1);
        wait_drain();
        n_cmp++;
        if (got[1].size() !== BLK) begin n_fail++; $display("FAIL mid_count got=%0d exp=%0d", got[1].size(), BLK); end
        else for (int i = 0; i < BLK; i++) begin
            n_cmp++; if (got[1][i] !== exp_q[1][i]) begin n_fail++; $display("FAIL mid_word i=%0d got=%h exp=%h", i, got[1][i], exp_q[1][i]); end
        end
        n_cmp++; if (err_o !== exp_err) begin n_fail++; $display("FAIL mid_err got=%b exp=%b", err_o, exp_err); end
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; tag_i = '0; axi_addr_i = '0; dma_data_ready_i = '1; axi_arready_i = 1'b1;
        axi_rvalid_i = 1'b0; axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 1'b0;
        model_clear();
        test_reset();
        test_ar_fields();
        test_credit();
        test_interleave();
        test_stall();
        test_errors();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not complete, required completion before 30000 cycles");
        $fatal(1);
    end
endmodule
